// File: rtl/window_gen_if.sv
// Pixel-stream in / sliding-window out bundle shared by window_gen and its source.
// Latency: none (wires only).
// Backpressure: none; the source drives a valid strobe that the window side always accepts.
interface window_gen_if #(
    parameter int WIN   = 31,
    parameter int PIX_W = 8
);
    logic                       i_pixel_valid;
    logic [PIX_W-1:0]           i_pixel;
    logic                       i_start;
    logic [9:0]                 i_width;
    logic [9:0]                 i_height;

    logic                       o_win_valid;
    logic [WIN*WIN*PIX_W-1:0]   o_window;
    logic [9:0]                 o_coor_x;
    logic [9:0]                 o_coor_y;
    logic                       o_start;
    logic                       o_end;
    logic                       o_err;

    // Pixel source side.
    modport master (
        output i_pixel_valid, i_pixel, i_start, i_width, i_height,
        input  o_win_valid, o_window, o_coor_x, o_coor_y, o_start, o_end, o_err
    );

    // Window generator side.
    modport slave (
        input  i_pixel_valid, i_pixel, i_start, i_width, i_height,
        output o_win_valid, o_window, o_coor_x, o_coor_y, o_start, o_end, o_err
    );
endinterface

// File: rtl/window_gen.sv
// Builds a WIN x WIN sliding pixel window from a raster stream using WIN-1 column-addressed line memories.
// Latency: 1 cycle from the accept of pixel (x+R, y+R) to o_win_valid for centre (x, y).
// Backpressure: none; every valid pixel is consumed, and valid-low cycles freeze all state.
module window_gen #(
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480,
    parameter int WIN        = 31,
    parameter int PIX_W      = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    window_gen_if.slave  bus
);
    localparam int R  = (WIN - 1) / 2;
    localparam int NL = WIN - 1;
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

    localparam logic [9:0] MAX_W10 = 10'(MAX_WIDTH);
    localparam logic [9:0] MAX_H10 = 10'(MAX_HEIGHT);
    localparam logic [9:0] WIN10   = 10'(WIN);
    localparam logic [9:0] R10     = 10'(R);
    localparam logic [9:0] D10     = 10'(2 * R);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Next pixel position inside the frame and the frame size in force.
    logic [9:0] in_x, in_y;
    logic [9:0] lat_w, lat_h;

    // Line memory k holds the row k+1 lines above the pixel being accepted.
    logic [PIX_W-1:0] line_mem [NL][MAX_WIDTH];
    logic [PIX_W-1:0] line_rd  [NL];

    logic [PIX_W-1:0]         win_q [WIN][WIN];
    logic [WIN*WIN*PIX_W-1:0] win_flat;

    logic       win_vld_q, start_q, end_q, err_q;
    logic [9:0] coor_x_q, coor_y_q;

    // Per-pixel decode.
    logic          cfg_ok;
    logic          take_start;
    logic          acc;
    logic          emit;
    logic          last_pix;
    logic          first_win;
    logic          err_set;
    logic [9:0]    cur_x, cur_y;
    logic [9:0]    act_w, act_h;
    logic [AW-1:0] wr_addr;

    // Classify the incoming pixel, resolve its frame position and compute the next FSM state.
    always_comb begin
        cfg_ok     = !((bus.i_width  > MAX_W10) || (bus.i_height > MAX_H10) ||
                       (bus.i_width  < WIN10)   || (bus.i_height < WIN10));
        take_start = bus.i_pixel_valid && bus.i_start;
        acc        = 1'b0;
        cur_x      = in_x;
        cur_y      = in_y;
        act_w      = lat_w;
        act_h      = lat_h;
        state_d    = state_q;

        if (take_start) begin
            // A start pixel is always (0,0) of a new frame, even mid-frame.
            cur_x = '0;
            cur_y = '0;
            act_w = bus.i_width;
            act_h = bus.i_height;
            acc   = cfg_ok;
        end else if (bus.i_pixel_valid && (state_q != IDLE)) begin
            acc = 1'b1;
        end

        // Only centres at least R from every edge produce a window, so columns never wrap.
        emit      = acc && (cur_y >= D10) && (cur_x >= D10) && (cur_x <= act_w - 10'd1);
        last_pix  = acc && (cur_x == act_w - 10'd1) && (cur_y == act_h - 10'd1);
        first_win = emit && (cur_x == D10) && (cur_y == D10);
        err_set   = (take_start && !cfg_ok) ||
                    (bus.i_pixel_valid && !bus.i_start && (state_q == IDLE));

        if (take_start) begin
            state_d = cfg_ok ? FILL : IDLE;
        end else if (acc) begin
            if (last_pix) begin
                state_d = IDLE;
            end else if ((state_q == FILL) && (cur_x == D10) && (cur_y == D10)) begin
                state_d = RUN;
            end
        end
    end

    assign wr_addr = cur_x[AW-1:0];

    // Read every line memory at the shared column pointer.
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            line_rd[k] = line_mem[k][wr_addr];
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Column/row counters and latched frame size; the column wraps at width-1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            in_x  <= '0;
            in_y  <= '0;
            lat_w <= '0;
            lat_h <= '0;
        end else begin
            if (take_start) begin
                lat_w <= bus.i_width;
                lat_h <= bus.i_height;
            end
            if (acc) begin
                if (last_pix) begin
                    in_x <= '0;
                    in_y <= '0;
                end else if (cur_x == act_w - 10'd1) begin
                    in_x <= '0;
                    in_y <= cur_y + 10'd1;
                end else begin
                    in_x <= cur_x + 10'd1;
                    in_y <= cur_y;
                end
            end else if (take_start) begin
                in_x <= '0;
                in_y <= '0;
            end
        end
    end

    // Line memories: each column slot ages by one line per accepted pixel; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            line_mem[0][wr_addr] <= bus.i_pixel;
            for (int k = 1; k < NL; k++) begin
                line_mem[k][wr_addr] <= line_rd[k-1];
            end
        end
    end

    // Window shifts left; the new right column is the line-memory outputs above the incoming pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (acc) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
            end
            for (int r = 0; r < WIN - 1; r++) begin
                win_q[r][WIN-1] <= line_rd[NL-1-r];
            end
            win_q[WIN-1][WIN-1] <= bus.i_pixel;
        end
    end

    // Output strobes, centre coordinates and the sticky error flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            win_vld_q <= 1'b0;
            start_q   <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
            coor_x_q  <= '0;
            coor_y_q  <= '0;
        end else begin
            win_vld_q <= emit;
            start_q   <= first_win;
            end_q     <= emit && last_pix;
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (emit) begin
                coor_x_q <= cur_x - R10;
                coor_y_q <= cur_y - R10;
            end
        end
    end

    // Flatten the window with row r, column c at element r*WIN+c.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                win_flat[(r*WIN+c)*PIX_W +: PIX_W] = win_q[r][c];
            end
        end
    end

    assign bus.o_window    = win_flat;
    assign bus.o_win_valid = win_vld_q;
    assign bus.o_start     = start_q;
    assign bus.o_end       = end_q;
    assign bus.o_err       = err_q;
    assign bus.o_coor_x    = coor_x_q;
    assign bus.o_coor_y    = coor_y_q;
endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen with a 3x3 window on small raster frames.
// Latency: expects each window one cycle after the pixel that completes it.
// Backpressure: exercises valid-low gaps; the DUT has no ready.
module tb_window_gen;
    localparam int W  = 3;
    localparam int R  = (W - 1) / 2;
    localparam int PW = 8;
    localparam int WW = W * W * PW;

    typedef struct {
        int             cx;
        int             cy;
        bit             st;
        bit             en;
        logic [WW-1:0]  win;
    } exp_t;

    logic i_clk;
    logic i_rst;

    window_gen_if #(.WIN(W), .PIX_W(PW)) bus ();

    window_gen #(
        .MAX_WIDTH (640),
        .MAX_HEIGHT(480),
        .WIN       (W),
        .PIX_W     (PW)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_win  = 0;
    int   n_end  = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] pix(input int x, input int y, input int seed);
        int v;
        v = y * 16 + x + seed;
        return v[7:0];
    endfunction

    function automatic logic [WW-1:0] exp_win(input int cx, input int cy, input int seed);
        logic [WW-1:0] v;
        v = '0;
        for (int r = 0; r < W; r++)
            for (int c = 0; c < W; c++)
                v[(r*W+c)*PW +: PW] = pix(cx - R + c, cy - R + r, seed);
        return v;
    endfunction

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic st, input logic [7:0] p,
                         input logic [9:0] w, input logic [9:0] h);
        @(negedge i_clk);
        bus.i_pixel_valid = v;
        bus.i_start       = st;
        bus.i_pixel       = p;
        bus.i_width       = w;
        bus.i_height      = h;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'h00, 10'd0, 10'd0);
    endtask

    // Sends a raster frame, stopping before (stop_x, stop_y) if reached; pushes the expected windows.
    task automatic run_frame(input int w, input int h, input int seed, input bit gap,
                             input int stop_x, input int stop_y);
        bit stopped;
        stopped = 1'b0;
        for (int y = 0; y < h && !stopped; y++) begin
            for (int x = 0; x < w && !stopped; x++) begin
                if (x == stop_x && y == stop_y) begin
                    stopped = 1'b1;
                end else begin
                    drive(1'b1, (x == 0 && y == 0), pix(x, y, seed), 10'(w), 10'(h));
                    if (x >= 2*R && y >= 2*R) begin
                        exp_t e;
                        e.cx  = x - R;
                        e.cy  = y - R;
                        e.st  = (x == 2*R && y == 2*R);
                        e.en  = (x == w-1 && y == h-1);
                        e.win = exp_win(x - R, y - R, seed);
                        exp_q.push_back(e);
                    end
                    if (gap) drive(1'b0, 1'b0, 8'hee, 10'(w), 10'(h));
                end
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_win_valid"}, WW'(bus.o_win_valid), '0);
        chk({tag, "_start"},     WW'(bus.o_start),     '0);
        chk({tag, "_end"},       WW'(bus.o_end),       '0);
        chk({tag, "_err"},       WW'(bus.o_err),       '0);
        chk({tag, "_coor_x"},    WW'(bus.o_coor_x),    '0);
        chk({tag, "_coor_y"},    WW'(bus.o_coor_y),    '0);
        chk({tag, "_window"},    bus.o_window,         '0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge i_clk);
        #2 i_rst = 1'b1;
        exp_q.delete();
        #1 chk_zero(tag);
        @(negedge i_clk);
        chk_zero(tag);
        i_rst = 1'b0;
    endtask

    // Monitor: pops one expected window whenever the DUT strobes o_win_valid.
    initial begin
        logic was_vld;
        exp_t e;
        forever begin
            @(posedge i_clk);
            was_vld = bus.i_pixel_valid;
            @(negedge i_clk);
            if (bus.o_win_valid === 1'b1) begin
                n_win++;
                if (bus.o_end === 1'b1) n_end++;
                chk("valid_after_gap", WW'(was_vld), WW'(1'b1));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window actual x=%0d y=%0d required none",
                             bus.o_coor_x, bus.o_coor_y);
                end else begin
                    e = exp_q.pop_front();
                    chk("coor_x", WW'(bus.o_coor_x), WW'(e.cx));
                    chk("coor_y", WW'(bus.o_coor_y), WW'(e.cy));
                    chk("o_start", WW'(bus.o_start), WW'(e.st));
                    chk("o_end", WW'(bus.o_end), WW'(e.en));
                    chk("window", bus.o_window, e.win);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, e0;
        int bad_w[4] = '{700, 8, 2, 8};
        int bad_h[4] = '{6, 500, 6, 2};

        i_rst             = 1'b1;
        bus.i_pixel_valid = 1'b0;
        bus.i_start       = 1'b0;
        bus.i_pixel       = '0;
        bus.i_width       = '0;
        bus.i_height      = '0;
        #3 chk_zero("reset");
        repeat (2) @(negedge i_clk);
        chk_zero("reset_hold");
        i_rst = 1'b0;

        // 8x6 ramp, continuous valid: 24 windows, centres (1,1)..(6,4).
        w0 = n_win; e0 = n_end;
        run_frame(8, 6, 0, 1'b0, -1, -1);
        idle(3);
        chk("frame8x6_count", WW'(n_win - w0), WW'(24));
        chk("frame8x6_ends",  WW'(n_end - e0), WW'(1));

        // Same frame with alternating valid.
        w0 = n_win; e0 = n_end;
        run_frame(8, 6, 0, 1'b1, -1, -1);
        idle(3);
        chk("gapped_count", WW'(n_win - w0), WW'(24));
        chk("gapped_ends",  WW'(n_end - e0), WW'(1));

        // Wider frame: 38 x 3 windows across two line wraps.
        w0 = n_win;
        run_frame(40, 5, 3, 1'b0, -1, -1);
        idle(3);
        chk("wide_count", WW'(n_win - w0), WW'(114));

        // Smallest legal frame: one window carrying both start and end.
        w0 = n_win; e0 = n_end;
        run_frame(3, 3, 9, 1'b0, -1, -1);
        idle(3);
        chk("min_count", WW'(n_win - w0), WW'(1));
        chk("min_ends",  WW'(n_end - e0), WW'(1));

        // Widest legal frame.
        w0 = n_win;
        run_frame(640, 3, 1, 1'b0, -1, -1);
        idle(3);
        chk("maxw_count", WW'(n_win - w0), WW'(638));

        // Restart at pixel 40 of row 10: 406 windows of the aborted frame, then 24, one end pulse.
        w0 = n_win; e0 = n_end;
        run_frame(48, 20, 0, 1'b0, 40, 10);
        run_frame(8, 6, 7, 1'b0, -1, -1);
        idle(3);
        chk("abort_count", WW'(n_win - w0), WW'(430));
        chk("abort_ends",  WW'(n_end - e0), WW'(1));
        chk("no_err_after_good", WW'(bus.o_err), WW'(1'b0));

        // Reset in the middle of RUN, then a fresh frame.
        run_frame(8, 6, 0, 1'b0, 4, 3);
        idle(2);
        pulse_reset("midrun_reset");
        w0 = n_win;
        run_frame(8, 6, 0, 1'b0, -1, -1);
        idle(3);
        chk("fresh_count", WW'(n_win - w0), WW'(24));

        // Stray pixel while idle.
        drive(1'b1, 1'b0, 8'h33, 10'd8, 10'd6);
        idle(2);
        chk("stray_err", WW'(bus.o_err), WW'(1'b1));

        // Illegal frame sizes: error, stay idle, no windows.
        for (int i = 0; i < 4; i++) begin
            pulse_reset("cfg_reset");
            w0 = n_win;
            drive(1'b1, 1'b1, 8'h00, 10'(bad_w[i]), 10'(bad_h[i]));
            for (int k = 1; k < 20; k++) drive(1'b1, 1'b0, 8'(k), 10'd0, 10'd0);
            idle(3);
            chk("cfg_err", WW'(bus.o_err), WW'(1'b1));
            chk("cfg_no_windows", WW'(n_win - w0), WW'(0));
        end

        chk("queue_drained", WW'(exp_q.size()), WW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
